// File: rtl/mem_if_pkg.sv
// Shared definitions for the cache line refill/writeback interface.
// Line geometry is reused by the cache controller; the state encoding is local to the responder.
package mem_if_pkg;

  localparam int LINE_W      = 256;
  localparam int OFFSET_BITS = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

endpackage : mem_if_pkg

// File: rtl/line_storage.sv
// DEPTH x LINE_W line array: synchronous write port, combinational read port.
// Kept apart from the FSM so a hard macro can replace it later.
module line_storage
  import mem_if_pkg::*;
#(
  parameter int DEPTH = 512,
  parameter int IDX_W = 9
) (
  input  logic              clk_i,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_widx,
  input  logic [LINE_W-1:0] i_wdata,
  input  logic [IDX_W-1:0]  i_ridx,
  output logic [LINE_W-1:0] o_rdata
);

  // Contents are deliberately left unreset so preloaded lines survive a reset.
  logic [LINE_W-1:0] r_mem [DEPTH];

  // Line write commit.
  always_ff @(posedge clk_i) begin
    if (i_we) begin
      r_mem[i_widx] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_ridx];

endmodule : line_storage

// File: rtl/line_memory_responder.sv
// Main-memory model behind the data cache line port: fixed-latency responder
// returning a one-cycle ack, with read data registered into the ack cycle.
module line_memory_responder
  import mem_if_pkg::*;
#(
  parameter int LATENCY = 10,
  parameter int DEPTH   = 512,
  parameter int IDX_W   = 9
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              write_i,
  input  logic [31:0]       addr_i,
  input  logic [LINE_W-1:0] data_i,
  output logic              ack_o,
  output logic [LINE_W-1:0] data_o
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_e             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [IDX_W-1:0]   r_idx;
  logic               r_wr;
  logic [LINE_W-1:0]  r_wdata;
  logic               r_ack;
  logic [LINE_W-1:0]  r_data;

  logic [IDX_W-1:0]   w_req_idx;
  logic [IDX_W-1:0]   w_rd_idx;
  logic               w_we;
  logic [LINE_W-1:0]  w_rdata;
  logic               w_unused_addr;

  assign w_req_idx     = addr_i[IDX_W+OFFSET_BITS-1:OFFSET_BITS];
  assign w_unused_addr = ^{addr_i[31:IDX_W+OFFSET_BITS], addr_i[OFFSET_BITS-1:0]};

  // Read index: the live address only matters for a LATENCY=1 read sampled in IDLE.
  always_comb begin
    w_rd_idx = r_idx;
    if (r_state == ST_IDLE) begin
      w_rd_idx = w_req_idx;
    end else begin
      w_rd_idx = r_idx;
    end
    w_we = (r_state == ST_ACK) && r_wr;
  end

  line_storage #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_storage (
    .clk_i   (clk_i),
    .i_we    (w_we),
    .i_widx  (r_idx),
    .i_wdata (r_wdata),
    .i_ridx  (w_rd_idx),
    .o_rdata (w_rdata)
  );

  // Request FSM; reset drops any pending write since w_we is gated by r_state.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_wr    <= 1'b0;
      r_wdata <= '0;
      r_ack   <= 1'b0;
      r_data  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_ack <= 1'b0;
          if (enable_i) begin
            r_idx   <= w_req_idx;
            r_wr    <= write_i;
            r_wdata <= data_i;
            if (LATENCY == 1) begin
              r_state <= ST_ACK;
              r_ack   <= 1'b1;
              if (!write_i) begin
                r_data <= w_rdata;
              end
            end else begin
              r_cnt   <= CNT_W'(LATENCY - 1);
              r_state <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          if (r_cnt == CNT_W'(1)) begin
            r_state <= ST_ACK;
            r_ack   <= 1'b1;
            if (!r_wr) begin
              r_data <= w_rdata;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_ACK: begin
          r_ack   <= 1'b0;
          r_cnt   <= '0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_ack   <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ack_o  = r_ack;
  assign data_o = r_data;

endmodule : line_memory_responder

// File: tb/tb_line_memory_responder.sv
// Directed bench: a LATENCY=10 responder and a LATENCY=1 responder driven by shared stimulus.
module tb_line_memory_responder;

  logic         clk;
  logic         rst_i;
  logic         enable_i;
  logic         write_i;
  logic [31:0]  addr_i;
  logic [255:0] data_i;
  logic         ack_a;
  logic [255:0] data_a;
  logic         ack_b;
  logic [255:0] data_b;

  int checks;
  int errors;

  localparam logic [255:0] PAT_A5   = {32{8'hA5}};
  localparam logic [255:0] PAT_L1   = {8{32'h0101_1EE1}};
  localparam logic [255:0] PAT_L5   = {8{32'h5555_0005}};
  localparam logic [255:0] PAT_CAFE = {64'h1234_5678_9ABC_DEF0, 64'h0F1E_2D3C_4B5A_6978,
                                       64'h1111_2222_3333_4444, 64'hDEAD_BEEF_0000_CAFE};

  line_memory_responder #(.LATENCY(10), .DEPTH(512), .IDX_W(9)) dut_a (
    .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .write_i(write_i),
    .addr_i(addr_i), .data_i(data_i), .ack_o(ack_a), .data_o(data_a)
  );

  line_memory_responder #(.LATENCY(1), .DEPTH(512), .IDX_W(9)) dut_b (
    .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .write_i(write_i),
    .addr_i(addr_i), .data_i(data_i), .ack_o(ack_b), .data_o(data_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b1;
  endtask

  // One request, enable held for the sampling edge only; records ack position (negedges after the sampling edge).
  task automatic run_req(input logic w, input logic [31:0] a, input logic [255:0] d, input int lat,
                         input logic mid_change, output int first_ack, output int n_acks,
                         output logic [255:0] dat);
    logic        ack_v;
    logic [255:0] dat_v;
    @(negedge clk);
    enable_i = 1'b1; write_i = w; addr_i = a; data_i = d;
    @(posedge clk);
    first_ack = -1; n_acks = 0; dat = '0;
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      if (j == 0) begin
        enable_i = 1'b0;
        if (mid_change) begin
          addr_i = 32'h0000_FFE0; data_i = ~d;
        end else begin
          write_i = 1'bx; addr_i = 'x;
        end
      end
      ack_v = (lat == 1) ? ack_b : ack_a;
      dat_v = (lat == 1) ? data_b : data_a;
      if (ack_v === 1'b1) begin
        n_acks++;
        if (first_ack < 0) begin
          first_ack = j; dat = dat_v;
        end
      end
    end
  endtask

  initial begin
    int           fa;
    int           na;
    logic [255:0] dv;
    int           ack_pos[$];
    checks = 0; errors = 0;
    rst_i = 1'b0; enable_i = 1'b0; write_i = 1'b0; addr_i = '0; data_i = '0;
    #12;
    check("reset_ack_a", {255'd0, ack_a}, 256'd0);
    check("reset_data_a", data_a, 256'd0);
    check("reset_ack_b", {255'd0, ack_b}, 256'd0);
    check("reset_data_b", data_b, 256'd0);
    @(negedge clk);
    rst_i = 1'b1;

    // Front-door preload of lines 3, 1 and 5.
    run_req(1'b1, 32'h60, PAT_A5, 10, 1'b0, fa, na, dv);
    check("pre3_ack_pos", fa, 9);
    check("pre3_data_unchanged", dv, 256'd0);
    run_req(1'b1, 32'h20, PAT_L1, 10, 1'b0, fa, na, dv);
    check("pre1_nacks", na, 1);
    run_req(1'b1, 32'hA0, PAT_L5, 10, 1'b0, fa, na, dv);
    check("pre5_ack_pos", fa, 9);

    do_reset();
    check("reset2_data_a", data_a, 256'd0);

    run_req(1'b0, 32'h60, '0, 10, 1'b0, fa, na, dv);
    check("refill_ack_pos", fa, 9);
    check("refill_nacks", na, 1);
    check("refill_data", dv, PAT_A5);

    run_req(1'b1, 32'h40, PAT_CAFE, 10, 1'b0, fa, na, dv);
    check("wb_ack_pos", fa, 9);
    check("wb_data_unchanged", dv, PAT_A5);
    run_req(1'b0, 32'h40, '0, 10, 1'b0, fa, na, dv);
    check("raw_data", dv, PAT_CAFE);

    run_req(1'b0, 32'h20, '0, 10, 1'b1, fa, na, dv);
    check("mid_ack_pos", fa, 9);
    check("mid_nacks", na, 1);
    check("mid_data", dv, PAT_L1);

    // Held enable on a wrapping address: acks every LATENCY+1 cycles.
    @(negedge clk);
    enable_i = 1'b1; write_i = 1'b0; addr_i = 32'h2000_0020;
    @(posedge clk);
    ack_pos.delete();
    for (int j = 0; j < 35; j++) begin
      @(negedge clk);
      if (ack_a === 1'b1) begin
        ack_pos.push_back(j);
        check("held_data", data_a, PAT_L1);
      end
    end
    enable_i = 1'b0;
    check("held_count", ack_pos.size(), 3);
    if (ack_pos.size() == 3) begin
      check("held_pos0", ack_pos[0], 9);
      check("held_pos1", ack_pos[1], 20);
      check("held_pos2", ack_pos[2], 31);
    end
    repeat (15) @(negedge clk);

    // Reset during a write: write must be dropped.
    @(negedge clk);
    enable_i = 1'b1; write_i = 1'b1; addr_i = 32'hA0; data_i = ~PAT_L5;
    @(posedge clk);
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      if (j == 0) enable_i = 1'b0;
    end
    rst_i = 1'b0;
    #1;
    check("rst_mid_ack", {255'd0, ack_a}, 256'd0);
    check("rst_mid_data", data_a, 256'd0);
    @(negedge clk);
    rst_i = 1'b1;
    run_req(1'b0, 32'hA0, '0, 10, 1'b0, fa, na, dv);
    check("rst_mid_line5", dv, PAT_L5);
    check("rst_mid_ack_pos", fa, 9);

    // LATENCY=1 instance.
    run_req(1'b0, 32'h60, '0, 1, 1'b0, fa, na, dv);
    check("l1_ack_pos", fa, 0);
    check("l1_nacks", na, 1);
    check("l1_data", dv, PAT_A5);

    @(negedge clk);
    enable_i = 1'b1; write_i = 1'b0; addr_i = 32'h60;
    @(posedge clk);
    ack_pos.delete();
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (ack_b === 1'b1) ack_pos.push_back(j);
    end
    enable_i = 1'b0;
    check("l1_held_count", ack_pos.size(), 4);
    if (ack_pos.size() == 4) begin
      check("l1_held_pos0", ack_pos[0], 0);
      check("l1_held_pos3", ack_pos[3], 6);
    end
    check("l1_held_data", data_b, PAT_A5);
    repeat (15) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_line_memory_responder
